// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings, instruction field layout and FSM states for the ALU issue controller.
package alu_issue_ctrl_pkg;

    localparam int DATA_W  = 8;
    localparam int IDX_W   = 2;
    localparam int NREGS   = 4;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 4;

    localparam logic [2:0] FUNC_NOP = 3'b000;
    localparam logic [2:0] FUNC_ADD = 3'b001;

    localparam int FUNC_LSB    = 13;
    localparam int USE_IMM_BIT = 12;
    localparam int RD_LSB      = 10;
    localparam int RS1_LSB     = 8;
    localparam int RS2_LSB     = 6;
    localparam int IMM_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    function automatic logic [2:0] instr_func(input logic [INSTR_W-1:0] ins);
        return ins[FUNC_LSB +: 3];
    endfunction

    function automatic logic instr_use_imm(input logic [INSTR_W-1:0] ins);
        return ins[USE_IMM_BIT];
    endfunction

    function automatic logic [IDX_W-1:0] instr_rd(input logic [INSTR_W-1:0] ins);
        return ins[RD_LSB +: IDX_W];
    endfunction

    function automatic logic [IDX_W-1:0] instr_rs1(input logic [INSTR_W-1:0] ins);
        return ins[RS1_LSB +: IDX_W];
    endfunction

    // rs2 overlays the top of the immediate field
    function automatic logic [IDX_W-1:0] instr_rs2(input logic [INSTR_W-1:0] ins);
        return ins[RS2_LSB +: IDX_W];
    endfunction

    function automatic logic [DATA_W-1:0] instr_imm(input logic [INSTR_W-1:0] ins);
        return ins[IMM_LSB +: DATA_W];
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x8 register file: two async read ports, a load port and a writeback port.
module alu_regfile
    import alu_issue_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [IDX_W-1:0]  ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [IDX_W-1:0]  rb_addr,
    output logic [DATA_W-1:0] rb_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
            // writeback is assigned last so it overrides a same-index load
            if (wb_en) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to a combinational ALU, waits ALU_LAT cycles,
// then writes the result and {V,N,Z} flags back into the register file.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic [15:0] i_instr,
    input  logic        i_ld_en,
    input  logic [1:0]  i_ld_addr,
    input  logic [7:0]  i_ld_data,
    output logic [7:0]  o_alu_s1,
    output logic [7:0]  o_alu_s2,
    output logic        o_alu_en,
    output logic [2:0]  o_alu_func,
    input  logic [7:0]  i_alu_result,
    input  logic        i_alu_zero,
    input  logic        i_alu_negative,
    input  logic        i_alu_overflow,
    output logic        o_wb_valid,
    output logic [1:0]  o_wb_rd,
    output logic [7:0]  o_wb_data,
    output logic [2:0]  o_flags
);

    // state | meaning
    // IDLE  | ready for an instruction
    // ISSUE | operands read, ALU inputs registered
    // WAIT  | ALU settling, counter runs ALU_LAT-1 down to 0
    // WB    | result and flags captured at the end of this cycle

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);

    state_t              state;
    state_t              state_nxt;
    logic [INSTR_W-1:0]  instr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                handshake;
    logic                wb_write;
    logic [2:0]          func_q;
    logic [DATA_W-1:0]   rd_a;
    logic [DATA_W-1:0]   rd_b;

    assign func_q        = instr_func(instr_q);
    assign o_instr_ready = (state == ST_IDLE) && i_rst_n;
    assign handshake     = i_instr_valid && o_instr_ready;
    assign wb_write      = (state == ST_WB) && (func_q != FUNC_NOP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (handshake) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (cnt_q == '0) state_nxt = ST_WB;
            ST_WB:    state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (state == ST_ISSUE) begin
            cnt_q <= LAT_LOAD;
        end else if ((state == ST_WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            instr_q    <= '0;
            o_alu_s1   <= '0;
            o_alu_s2   <= '0;
            o_alu_en   <= 1'b0;
            o_alu_func <= '0;
            o_wb_valid <= 1'b0;
            o_wb_rd    <= '0;
            o_wb_data  <= '0;
            o_flags    <= '0;
        end else begin
            o_wb_valid <= wb_write;
            if (handshake) begin
                instr_q <= i_instr;
            end
            if (state == ST_ISSUE) begin
                o_alu_s1   <= rd_a;
                o_alu_s2   <= instr_use_imm(instr_q) ? instr_imm(instr_q) : rd_b;
                o_alu_func <= func_q;
                o_alu_en   <= (func_q != FUNC_NOP);
            end
            if (state == ST_WB) begin
                o_alu_en <= 1'b0;
            end
            if (wb_write) begin
                o_wb_rd   <= instr_rd(instr_q);
                o_wb_data <= i_alu_result;
                o_flags   <= {i_alu_overflow, i_alu_negative, i_alu_zero};
            end
        end
    end

    alu_regfile u_regfile (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .ld_en   (i_ld_en),
        .ld_addr (i_ld_addr),
        .ld_data (i_ld_data),
        .wb_en   (wb_write),
        .wb_addr (instr_rd(instr_q)),
        .wb_data (i_alu_result),
        .ra_addr (instr_rs1(instr_q)),
        .ra_data (rd_a),
        .rb_addr (instr_rs2(instr_q)),
        .rb_data (rd_b)
    );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: vector table, hand sequences and random instructions vs. an instruction-level model.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance with ALU_LAT=1
    logic        rst_n, valid, ready, ld_en, en, z, n, v, wbv;
    logic [15:0] instr;
    logic [1:0]  ld_addr, wbrd;
    logic [7:0]  ld_data, s1, s2, res, wbd;
    logic [2:0]  func, flags;

    // instance with ALU_LAT=4
    logic        rst4_n, valid4, ready4, ld_en4, en4, z4, n4, v4, wbv4;
    logic [15:0] instr4;
    logic [1:0]  ld_addr4, wbrd4;
    logic [7:0]  ld_data4, s1_4, s2_4, res4, wbd4;
    logic [2:0]  func4, flags4;

    // bench-side ALU: returns {V,N,Z,result}
    function automatic logic [10:0] alu_f(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       ov;
        w  = 9'd0;
        r  = 8'd0;
        ov = 1'b0;
        case (f)
            3'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; ov = w[8]; end
            3'd2: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; ov = w[8]; end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = ~a;
            3'd7: r = b;
            default: r = 8'd0;
        endcase
        return {ov, r[7], (r == 8'd0), r};
    endfunction

    assign {v, n, z, res}     = alu_f(func, s1, s2);
    assign {v4, n4, z4, res4} = alu_f(func4, s1_4, s2_4);

    alu_issue_ctrl #(.ALU_LAT(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr_valid(valid), .o_instr_ready(ready),
        .i_instr(instr), .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
        .o_alu_s1(s1), .o_alu_s2(s2), .o_alu_en(en), .o_alu_func(func),
        .i_alu_result(res), .i_alu_zero(z), .i_alu_negative(n), .i_alu_overflow(v),
        .o_wb_valid(wbv), .o_wb_rd(wbrd), .o_wb_data(wbd), .o_flags(flags)
    );

    alu_issue_ctrl #(.ALU_LAT(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst4_n), .i_instr_valid(valid4), .o_instr_ready(ready4),
        .i_instr(instr4), .i_ld_en(ld_en4), .i_ld_addr(ld_addr4), .i_ld_data(ld_data4),
        .o_alu_s1(s1_4), .o_alu_s2(s2_4), .o_alu_en(en4), .o_alu_func(func4),
        .i_alu_result(res4), .i_alu_zero(z4), .i_alu_negative(n4), .i_alu_overflow(v4),
        .o_wb_valid(wbv4), .o_wb_rd(wbrd4), .o_wb_data(wbd4), .o_flags(flags4)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] mr [4];
    logic [2:0] mf;

    typedef struct {
        logic [15:0] ins;
        logic        exp_wb;
        logic [7:0]  exp_data;
        logic [2:0]  exp_flags;
    } vec_t;
    vec_t tab [7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] f, input logic ui, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [7:0] imm);
        return {f, ui, rd, rs1, imm};
    endfunction

    task automatic do_load(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        mr[a] = d;
    endtask

    // Runs one instruction on the LAT=1 instance, optionally loading a register during ISSUE.
    task automatic exec1(input logic [15:0] ins, input bit li_en, input logic [1:0] li, input logic [7:0] lv,
                         output logic got_wb, output logic [7:0] got_data, output logic [2:0] got_flags);
        logic [2:0]  f;
        logic [7:0]  e1, e2;
        logic [10:0] e;
        int          wt, lat, hits;
        f  = ins[15:13];
        e1 = mr[ins[9:8]];
        e2 = ins[12] ? ins[7:0] : mr[ins[7:6]];
        e  = alu_f(f, e1, e2);
        @(negedge clk);
        valid = 1'b1; instr = ins;
        wt = 0;
        while (!ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        chk("hs_ready", ready, 1);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        instr = 16'($urandom);
        if (li_en) begin
            ld_en = 1'b1; ld_addr = li; ld_data = lv;
        end
        hits = 0; lat = 0; got_data = 8'd0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ld_en = 1'b0;
                if (li_en) mr[li] = lv;
                chk("busy", ready, 0);
                chk("alu_en", en, (f != 3'd0));
                chk("alu_s1", s1, e1);
                chk("alu_s2", s2, e2);
                chk("alu_func", func, f);
            end
            if (c == 3) begin
                chk("ready_back", ready, 1);
                chk("alu_en_clr", en, 0);
            end
            if (wbv) begin
                hits++;
                if (lat == 0) lat = c;
                got_data = wbd;
                chk("wb_rd", wbrd, ins[11:10]);
            end
        end
        got_wb = (hits != 0);
        got_flags = flags;
        if (f != 3'd0) begin
            chk("wb_lat", lat, 3);
            chk("wb_hits", hits, 1);
            chk("wb_data", got_data, e[7:0]);
            chk("flags", flags, e[10:8]);
            mr[ins[11:10]] = e[7:0];
            mf = e[10:8];
        end else begin
            chk("nop_wb", hits, 0);
            chk("nop_flags", flags, mf);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic        gw;
        logic [7:0]  gd;
        logic [2:0]  gf;
        logic [10:0] ea, eb;
        logic [15:0] ia, ib;
        int          low, lat, hits;

        rst_n = 1'b0; valid = 1'b0; instr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        rst4_n = 1'b0; valid4 = 1'b0; instr4 = '0; ld_en4 = 1'b0; ld_addr4 = '0; ld_data4 = '0;
        for (int i = 0; i < 4; i++) mr[i] = 8'd0;
        mf = 3'd0;

        tab[0] = '{mk(FUNC_ADD, 1'b0, 2'd0, 2'd0, 8'h40), 1'b1, 8'd0,   3'b001};
        tab[1] = '{mk(FUNC_ADD, 1'b0, 2'd1, 2'd2, 8'hC0), 1'b1, 8'd0,   3'b001};
        tab[2] = '{mk(FUNC_ADD, 1'b1, 2'd0, 2'd0, 8'd100), 1'b1, 8'd44, 3'b100};
        tab[3] = '{mk(FUNC_ADD, 1'b1, 2'd0, 2'd3, 8'd0),  1'b1, 8'd0,   3'b001};
        tab[4] = '{mk(FUNC_ADD, 1'b0, 2'd3, 2'd1, 8'h80), 1'b1, 8'd127, 3'b000};
        tab[5] = '{mk(FUNC_NOP, 1'b0, 2'd2, 2'd1, 8'h40), 1'b0, 8'd0,   3'b000};
        tab[6] = '{mk(FUNC_ADD, 1'b0, 2'd1, 2'd1, 8'h40), 1'b1, 8'hC8,  3'b010};

        repeat (3) @(negedge clk);
        chk("rst_outs", {ready, en, s1, s2, func, wbv, wbrd, wbd, flags}, 0);
        chk("rst_ready4", ready4, 0);
        rst_n = 1'b1; rst4_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", ready, 1);

        // vectors 0-1 read the reset contents; then preload and run the rest
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                do_load(2'd1, 8'd100);
                do_load(2'd2, 8'd27);
                do_load(2'd0, 8'd200);
            end
            exec1(tab[i].ins, 1'b0, 2'd0, 8'd0, gw, gd, gf);
            chk($sformatf("tab%0d_wb", i), gw, tab[i].exp_wb);
            if (tab[i].exp_wb) chk($sformatf("tab%0d_data", i), gd, tab[i].exp_data);
            chk($sformatf("tab%0d_flags", i), gf, tab[i].exp_flags);
        end

        // back-to-back with valid held high
        ia = mk(FUNC_ADD, 1'b1, 2'd1, 2'd2, 8'd1);
        ib = mk(FUNC_ADD, 1'b0, 2'd2, 2'd1, 8'h40);
        ea = alu_f(3'd1, mr[2], 8'd1);
        mr[1] = ea[7:0];
        eb = alu_f(3'd1, mr[1], mr[1]);
        @(negedge clk);
        valid = 1'b1; instr = ia;
        chk("b2b_ready_a", ready, 1);
        @(posedge clk);
        @(negedge clk);
        instr = ib;
        low = 0;
        while (!ready && low < 10) begin
            low++;
            @(negedge clk);
        end
        chk("b2b_ready_low", low, 3);
        chk("b2b_wb_a", {wbv, wbd}, {1'b1, ea[7:0]});
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (wbv && lat == 0) begin
                lat = c;
                chk("b2b_wb_b", wbd, eb[7:0]);
            end
        end
        chk("b2b_lat_b", lat, 3);
        mr[2] = eb[7:0];
        mf = eb[10:8];

        // load and writeback hit R3 in the same cycle
        do_load(2'd2, 8'h08);
        @(negedge clk);
        valid = 1'b1; instr = mk(FUNC_ADD, 1'b1, 2'd3, 2'd2, 8'h08);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 2'd3; ld_data = 8'h55;
        @(negedge clk);
        ld_en = 1'b0;
        chk("coll_wb", {wbv, wbrd, wbd}, {1'b1, 2'd3, 8'h10});
        mr[3] = 8'h10;
        mf = 3'b000;
        exec1(mk(FUNC_ADD, 1'b1, 2'd0, 2'd3, 8'd0), 1'b0, 2'd0, 8'd0, gw, gd, gf);
        chk("coll_r3", gd, 8'h10);
        exec1(mk(FUNC_NOP, 1'b1, 2'd1, 2'd0, 8'd9), 1'b0, 2'd0, 8'd0, gw, gd, gf);

        // load into rs1 during ISSUE: operand must be the old value
        exec1(mk(FUNC_ADD, 1'b1, 2'd2, 2'd1, 8'd3), 1'b1, 2'd1, 8'hA5, gw, gd, gf);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) do_load(2'($urandom), 8'($urandom));
            exec1(16'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom), gw, gd, gf);
        end

        // ALU_LAT=4: reset during WAIT drops the op
        @(negedge clk);
        ld_en4 = 1'b1; ld_addr4 = 2'd1; ld_data4 = 8'd5;
        @(negedge clk);
        ld_en4 = 1'b0;
        valid4 = 1'b1; instr4 = mk(FUNC_ADD, 1'b1, 2'd2, 2'd1, 8'd3);
        chk("l4_ready", ready4, 1);
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
        @(negedge clk);
        chk("l4_alu_s1", {en4, s1_4}, {1'b1, 8'd5});
        @(negedge clk);
        rst4_n = 1'b0;
        @(negedge clk);
        chk("l4_rst_outs", {ready4, en4, s1_4, s2_4, func4, wbv4, wbrd4, wbd4, flags4}, 0);
        rst4_n = 1'b1;
        hits = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (wbv4) hits++;
        end
        chk("l4_no_wb", hits, 0);
        chk("l4_idle", ready4, 1);
        valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) chk("l4_r1_cleared", s1_4, 8'd0);
            if (wbv4 && lat == 0) begin
                lat = c;
                chk("l4_wb", {wbrd4, wbd4, flags4}, {2'd2, 8'd3, 3'b000});
            end
        end
        chk("l4_lat", lat, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
